// File: rtl/data_io_upload_if.sv
// ioctl read-side bus between the upload SPI responder and core memory.
// master: the upload block (drives upload/index/rd/addr, receives din/clkref)
// slave : the memory side (drives din/clkref)
//   ioctl_upload  upload active
//   ioctl_index   menu index of the file
//   ioctl_rd      one-cycle read strobe
//   ioctl_addr    word address of the read
//   ioctl_din     read data, valid DATA_LAT cycles after ioctl_rd
//   ioctl_clkref  read-enable reference (only used with DATA_IO_UPLOAD_CLKREF_EN)
interface data_io_upload_if;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 8;

  logic              ioctl_upload;
  logic [IDX_W-1:0]  ioctl_index;
  logic              ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [DATA_W-1:0] ioctl_din;
  logic              ioctl_clkref;

  modport master (
    output ioctl_upload,
    output ioctl_index,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_clkref
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_index,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_clkref
  );
endinterface

// File: rtl/data_io_upload.sv
// SPI responder returning core memory contents to the ARM io controller
// (FPGA->ARM direction of the file-transfer channel). Commands arrive on
// SPI_SS2; 16-bit words are fetched via the ioctl read handshake and shifted
// out MSB-first on SPI_DO, high byte first. Everything runs in clk_sys; SCK,
// SS2 and DI are oversampled through 2-FF synchronisers.
//
// Ports:
//   clk_sys, reset_n      system clock (>= 4x SCK), async active-low reset
//   SPI_SCK/SS2/DI        SPI clock, chip select (active low), ARM->FPGA data
//   SPI_DO, spi_do_en     FPGA->ARM data and its drive enable
//   underrun              sticky, set when a word was not ready in time
//   ioctl                 read bus (data_io_upload_if.master)
//
// Optional feature: define DATA_IO_UPLOAD_CLKREF_EN to hold each read request
// until a rising edge of ioctl_clkref (SDRAM slot alignment).
module data_io_upload #(
  parameter int unsigned DATA_LAT      = 2,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             SPI_SCK,
  input  logic             SPI_SS2,
  input  logic             SPI_DI,
  output logic             SPI_DO,
  output logic             spi_do_en,
  output logic             underrun,
  data_io_upload_if.master ioctl
);

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LAT_W  = 3;

  localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
  localparam logic [7:0] CMD_FILE_RX     = 8'h56;
  localparam logic [7:0] CMD_FILE_RX_DAT = 8'h57;

  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_WAIT, RD_FULL} rd_state_t;

  // SPI side registers
  logic [1:0]        r_sck_sync, r_ss2_sync, r_di_sync;
  logic              r_sck_d;
  logic [2:0]        r_bit_cnt;
  logic [2:0]        r_byte_cnt;
  logic [6:0]        r_rx;
  logic [7:0]        r_cmd;
  logic [7:0]        r_tx;
  logic              r_hilo;      // 1: next load is the low byte
  logic              r_uword;     // current word is being sent as underrun filler
  logic              r_do_en;
  logic              r_upload;
  logic [7:0]        r_index;
  logic              r_underrun;

  // read side registers
  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_valid;
  logic              r_rd;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LAT_W-1:0]  r_lat_cnt;

  logic       w_sck, w_ss2, w_di;
  logic       w_sck_rise, w_sck_fall;
  logic [7:0] w_byte;
  logic       w_byte_done, w_is_cmd;
  logic       w_rx_dat, w_load_hi, w_load_lo, w_consume, w_hi_under;
  logic       w_arg1, w_start, w_stop, w_index_wr;
  logic       w_rd_go;

  assign w_sck = r_sck_sync[1];
  assign w_ss2 = r_ss2_sync[1];
  assign w_di  = r_di_sync[1];

  // Byte-level event decode from the synchronised SPI stream
  always_comb begin
    w_sck_rise  = w_sck & ~r_sck_d;
    w_sck_fall  = ~w_sck & r_sck_d;
    w_byte      = {r_rx, w_di};
    w_byte_done = ~w_ss2 & w_sck_rise & (r_bit_cnt == 3'd7);
    w_is_cmd    = (r_byte_cnt == 3'd0);
    w_rx_dat    = w_byte_done &
                  ((w_is_cmd & (w_byte == CMD_FILE_RX_DAT)) |
                   (~w_is_cmd & (r_cmd == CMD_FILE_RX_DAT)));
    // the command byte always restarts a word at its high byte
    w_load_lo   = w_rx_dat & ~w_is_cmd & r_hilo;
    w_load_hi   = w_rx_dat & ~w_load_lo;
    w_consume   = w_load_lo & ~r_uword;
    w_hi_under  = w_load_hi & ~r_buf_valid;
    w_arg1      = w_byte_done & (r_byte_cnt == 3'd1);
    w_start     = w_arg1 & (r_cmd == CMD_FILE_RX) & (w_byte != 8'h00);
    w_stop      = w_arg1 & (r_cmd == CMD_FILE_RX) & (w_byte == 8'h00);
    w_index_wr  = w_arg1 & (r_cmd == CMD_FILE_INDEX);
  end

`ifdef DATA_IO_UPLOAD_CLKREF_EN
  logic r_clkref_d;

  // clkref edge detector for slot-aligned read requests
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_clkref_d <= 1'b0;
    else          r_clkref_d <= ioctl.ioctl_clkref;
  end

  assign w_rd_go = ioctl.ioctl_clkref & ~r_clkref_d;
`else
  logic w_unused_clkref;
  assign w_unused_clkref = ioctl.ioctl_clkref;
  assign w_rd_go         = 1'b1;
`endif

  // SPI receive/transmit and command handling
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync <= 2'b00;
      r_ss2_sync <= 2'b11;
      r_di_sync  <= 2'b00;
      r_sck_d    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 3'd0;
      r_rx       <= 7'd0;
      r_cmd      <= 8'd0;
      r_tx       <= 8'd0;
      r_hilo     <= 1'b0;
      r_uword    <= 1'b0;
      r_do_en    <= 1'b0;
      r_upload   <= 1'b0;
      r_index    <= 8'd0;
      r_underrun <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[0], SPI_SCK};
      r_ss2_sync <= {r_ss2_sync[0], SPI_SS2};
      r_di_sync  <= {r_di_sync[0], SPI_DI};
      r_sck_d    <= w_sck;

      if (w_ss2) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 3'd0;
        r_do_en    <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_rx      <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (r_byte_cnt != 3'd7) r_byte_cnt <= r_byte_cnt + 3'd1;
            if (w_is_cmd)           r_cmd      <= w_byte;
          end
        end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
          // falling edge between bytes must not disturb a freshly loaded byte
          r_tx <= {r_tx[6:0], 1'b0};
        end

        if (w_load_hi) begin
          r_tx    <= r_buf_valid ? r_buf[15:8] : UNDERRUN_BYTE;
          r_uword <= ~r_buf_valid;
          r_hilo  <= 1'b1;
          r_do_en <= 1'b1;
        end else if (w_load_lo) begin
          r_tx   <= r_uword ? UNDERRUN_BYTE : r_buf[7:0];
          r_hilo <= 1'b0;
        end
      end

      if (w_index_wr) r_index <= w_byte;

      if (w_start) begin
        r_upload   <= 1'b1;
        r_underrun <= 1'b0;
      end else begin
        if (w_stop)     r_upload   <= 1'b0;
        if (w_hi_under) r_underrun <= 1'b1;
      end
    end
  end

  // Read FSM: keeps one word prefetched while the upload is active
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RD_IDLE;
      r_addr      <= '0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_rd        <= 1'b0;
      r_rd_addr   <= '0;
      r_lat_cnt   <= '0;
    end else begin
      r_rd <= 1'b0;
      if (w_start) begin
        // restart aborts any read in flight and refetches word 0
        r_addr      <= '0;
        r_buf_valid <= 1'b0;
        r_state     <= RD_REQ;
      end else if (w_stop) begin
        r_state <= RD_IDLE;
      end else begin
        if (w_consume) begin
          r_buf_valid <= 1'b0;
          r_addr      <= r_addr + ADDR_W'(1);
        end
        unique case (r_state)
          RD_IDLE: begin
            if (r_upload && !r_buf_valid) r_state <= RD_REQ;
          end
          RD_REQ: begin
            if (w_rd_go) begin
              r_rd      <= 1'b1;
              r_rd_addr <= r_addr;
              r_lat_cnt <= '0;
              r_state   <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (r_lat_cnt == LAT_W'(DATA_LAT)) begin
              r_buf       <= ioctl.ioctl_din;
              r_buf_valid <= 1'b1;
              r_state     <= RD_FULL;
            end else begin
              r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
          end
          RD_FULL: begin
            if (w_consume) r_state <= RD_REQ;
          end
          default: r_state <= RD_IDLE;
        endcase
      end
    end
  end

  assign SPI_DO             = r_tx[7];
  assign spi_do_en          = r_do_en;
  assign underrun           = r_underrun;
  assign ioctl.ioctl_upload = r_upload;
  assign ioctl.ioctl_index  = r_index;
  assign ioctl.ioctl_rd     = r_rd;
  assign ioctl.ioctl_addr   = r_rd_addr;

endmodule

// File: tb/tb_data_io_upload.sv
// Testbench for data_io_upload: SPI master model at clk_sys/4, memory model
// with fixed read latency, scoreboard of expected upload bytes.
module tb_data_io_upload;
  localparam int LAT = 7;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic SPI_SCK = 1'b0;
  logic SPI_SS2 = 1'b1;
  logic SPI_DI  = 1'b0;
  logic SPI_DO, spi_do_en, underrun;

  data_io_upload_if bus ();

  data_io_upload #(.DATA_LAT(LAT), .UNDERRUN_BYTE(8'hFF)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .SPI_SCK   (SPI_SCK),
    .SPI_SS2   (SPI_SS2),
    .SPI_DI    (SPI_DI),
    .SPI_DO    (SPI_DO),
    .spi_do_en (spi_do_en),
    .underrun  (underrun),
    .ioctl     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q [$];
  logic [24:0] rd_q  [$];
  int          rd_cnt = 0;
  logic [7:0]  f_tx  [$];
  logic [7:0]  f_rx  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=none expected=entry", tag);
  endtask

  function automatic logic [15:0] mem_word(input logic [24:0] a);
    if (a == 25'd0) return 16'hA1B2;
    if (a == 25'd1) return 16'hC3D4;
    return {a[7:0] ^ 8'h3C, ~a[7:0]};
  endfunction

  // memory: data valid exactly LAT cycles after the rd strobe cycle
  logic        dv [LAT];
  logic [24:0] da [LAT];
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin dv[i] <= 1'b0; da[i] <= '0; end
    end else begin
      dv[0] <= bus.ioctl_rd;
      da[0] <= bus.ioctl_addr;
      for (int i = 1; i < LAT; i++) begin dv[i] <= dv[i-1]; da[i] <= da[i-1]; end
    end
  end
  always_comb bus.ioctl_din = dv[LAT-1] ? mem_word(da[LAT-1]) : 16'hDEAD;

  // clkref toggles every 8 cycles
  logic [2:0] ck_cnt = 3'd0;
  logic       clkref_tb = 1'b0;
  always @(posedge clk_sys) begin
    ck_cnt <= ck_cnt + 3'd1;
    if (ck_cnt == 3'd7) clkref_tb <= ~clkref_tb;
  end
  assign bus.ioctl_clkref = clkref_tb;

  // read strobe monitor
  logic ck_p1 = 1'b0, ck_p2 = 1'b0, rd_prev = 1'b0;
  always @(negedge clk_sys) begin
    if (bus.ioctl_rd === 1'b1) begin
      rd_q.push_back(bus.ioctl_addr);
      rd_cnt++;
`ifdef DATA_IO_UPLOAD_CLKREF_EN
      check("rd_after_clkref_rise", {30'd0, ck_p2, ck_p1}, 32'd1);
`else
      check("rd_single_cycle", {31'd0, rd_prev}, 32'd0);
`endif
    end
    ck_p2   = ck_p1;
    ck_p1   = clkref_tb;
    rd_prev = bus.ioctl_rd;
  end

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SPI_DI = tx[i];
      repeat (2) @(negedge clk_sys);
      SPI_SCK = 1'b1;
      repeat (2) @(negedge clk_sys);
      rx[i]   = SPI_DO;
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic spi_frame();
    logic [7:0] r;
    f_rx.delete();
    @(negedge clk_sys);
    SPI_SS2 = 1'b0;
    repeat (3) @(negedge clk_sys);
    foreach (f_tx[i]) begin
      spi_xfer(f_tx[i], r);
      f_rx.push_back(r);
    end
    repeat (4) @(negedge clk_sys);
    SPI_SS2 = 1'b1;
    repeat (8) @(negedge clk_sys);
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    f_tx.delete();
    f_tx.push_back(a);
    f_tx.push_back(b);
    spi_frame();
  endtask

  task automatic push_words(input int w0, input int nw);
    logic [15:0] w;
    for (int k = 0; k < nw; k++) begin
      w = mem_word(25'(w0 + k));
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic push_ff(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'hFF);
  endtask

  // 0x57 followed by n dummy bytes; every received byte is scored
  task automatic rx_dat(input int n);
    logic [7:0] e;
    f_tx.delete();
    f_tx.push_back(8'h57);
    for (int k = 0; k < n; k++) f_tx.push_back(8'h00);
    spi_frame();
    for (int k = 1; k <= n; k++) begin
      if (exp_q.size() == 0) fail_now("rx_byte_no_expectation");
      else begin
        e = exp_q.pop_front();
        check("rx_byte", 32'(f_rx[k]), 32'(e));
      end
    end
  endtask

  task automatic check_rd(input logic [24:0] a);
    logic [24:0] got;
    if (rd_q.size() == 0) fail_now("rd_addr_missing");
    else begin
      got = rd_q.pop_front();
      check("rd_addr", 32'(got), 32'(a));
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_SPI_DO"},    32'(SPI_DO), 32'd0);
    check({pfx, "_do_en"},     32'(spi_do_en), 32'd0);
    check({pfx, "_upload"},    32'(bus.ioctl_upload), 32'd0);
    check({pfx, "_index"},     32'(bus.ioctl_index), 32'd0);
    check({pfx, "_rd"},        32'(bus.ioctl_rd), 32'd0);
    check({pfx, "_addr"},      32'(bus.ioctl_addr), 32'd0);
    check({pfx, "_underrun"},  32'(underrun), 32'd0);
  endtask

  initial begin
    logic [7:0]  r;
    logic [15:0] w1;
    int          n0;

    // power-on reset
    repeat (3) @(negedge clk_sys);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    // file index
    send2(8'h55, 8'h07);
    check("index", 32'(bus.ioctl_index), 32'h07);

    // upload start: prefetch of word 0
    send2(8'h56, 8'h01);
    repeat (40) @(negedge clk_sys);
    check("upload_on", 32'(bus.ioctl_upload), 32'd1);
    check("underrun_clear", 32'(underrun), 32'd0);
    check("rd_count_start", 32'(rd_cnt), 32'd1);
    check_rd(25'd0);

    // first two words: A1 B2 C3 D4
    push_words(0, 2);
    rx_dat(4);
    repeat (40) @(negedge clk_sys);
    check_rd(25'd1);
    check_rd(25'd2);
    check("rd_count_4b", 32'(rd_cnt), 32'd3);
    check("underrun_4b", 32'(underrun), 32'd0);

    // 64-byte stream with DATA_LAT=7, SCK=clk/4
    push_words(2, 32);
    rx_dat(64);
    repeat (40) @(negedge clk_sys);
    check("underrun_64b", 32'(underrun), 32'd0);
    check("rd_count_64b", 32'(rd_q.size()), 32'd32);
    for (int a = 3; a <= 34; a++) check_rd(25'(a));

    // stall: stop refills, buffered word 34 goes out then filler
    send2(8'h56, 8'h00);
    repeat (40) @(negedge clk_sys);
    check("upload_off", 32'(bus.ioctl_upload), 32'd0);
    n0 = rd_cnt;
    push_words(34, 1);
    push_ff(2);
    rx_dat(4);
    check("underrun_set", 32'(underrun), 32'd1);
    push_ff(2);
    rx_dat(2);
    repeat (40) @(negedge clk_sys);
    check("no_reads_when_stopped", 32'(rd_cnt), 32'(n0));
    check("underrun_sticky", 32'(underrun), 32'd1);

    // recovery: restart resends from word 0
    send2(8'h56, 8'h01);
    repeat (40) @(negedge clk_sys);
    check("underrun_cleared", 32'(underrun), 32'd0);
    check("upload_on_again", 32'(bus.ioctl_upload), 32'd1);
    check_rd(25'd0);
    push_words(0, 1);
    rx_dat(2);
    repeat (40) @(negedge clk_sys);
    check_rd(25'd1);
    check("underrun_after_recovery", 32'(underrun), 32'd0);

    // reset in the middle of a 0x57 frame
    @(negedge clk_sys);
    SPI_SS2 = 1'b0;
    repeat (3) @(negedge clk_sys);
    spi_xfer(8'h57, r);
    repeat (4) @(negedge clk_sys);
    w1 = mem_word(25'd1);
    check("midframe_do_en", 32'(spi_do_en), 32'd1);
    check("midframe_SPI_DO", 32'(SPI_DO), 32'(w1[15]));
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_idle_outputs("midreset");
    SPI_SS2 = 1'b1;
    reset_n = 1'b1;
    repeat (40) @(negedge clk_sys);
    check("post_reset_upload", 32'(bus.ioctl_upload), 32'd0);
    check("post_reset_no_reads", 32'(rd_q.size()), 32'd0);
    check("post_reset_do_en", 32'(spi_do_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_io_upload.md
Name: data_io_upload

Overview:
- SPI responder that returns core memory contents to the ARM io controller (file upload/save): the FPGA→ARM direction of the file-transfer channel.
- Decodes upload commands on SPI_SS2, reads 16-bit words from core memory through an ioctl read handshake, and shifts the bytes out MSB-first on SPI_DO.
- Runs entirely in clk_sys; SPI_SCK and SPI_SS2 are oversampled.

Parameters:
- DATA_LAT, 2: clk_sys cycles from the ioctl_rd pulse until ioctl_din is valid (1..7).
- UNDERRUN_BYTE, 8'hFF: byte sent when no word is buffered.

Ports:
- clk_sys  in  1  system clock, must be >= 4x SPI_SCK frequency
- reset_n  in  1  asynchronous, active-low reset
- SPI_SCK  in  1  SPI clock from ARM (asynchronous, sampled)
- SPI_SS2  in  1  chip select, active low
- SPI_DI  in  1  ARM→FPGA data
- SPI_DO  out  1  FPGA→ARM data
- spi_do_en  out  1  SPI_DO drive enable (top level tristates SPI_DO when low)
- ioctl_upload  out  1  upload active
- ioctl_index  out  8  menu index of the file
- ioctl_rd  out  1  one-cycle read strobe
- ioctl_addr  out  25  word address of the read
- ioctl_din  in  16  read data, valid DATA_LAT cycles after ioctl_rd
- ioctl_clkref  in  1  read-enable reference (optional feature only)
- underrun  out  1  sticky flag, cleared at upload start

Behaviour:
- Reset: all outputs 0; internal address 0; buffer empty; state RD_IDLE.
- Sampling: SCK, SS2 and DI pass through 2-FF synchronisers; SCK edges are detected on the synchronised value.
- SS2 high (deselected): bit counter and byte counter cleared, spi_do_en=0. The upload state and buffered word are kept.
- Rising SCK edge:
  - Shift DI into the receive register.
  - On the 8th bit, the byte is complete and the byte counter increments, saturating at 7.
  - Byte 0 is the command. Later bytes are arguments.
- Command 0x55 (FILE_INDEX): argument byte → ioctl_index.
- Command 0x56 (FILE_RX):
  - Nonzero argument: internal address=0, ioctl_upload=1, underrun=0, buffer flushed, prefetch of word 0 issued.
  - Zero argument: ioctl_upload=0, read FSM back to RD_IDLE.
- Command 0x57 (FILE_RX_DAT):
  - When the command byte completes, load the transmit register with buffer[15:8] and set spi_do_en=1.
  - Each subsequent byte completion alternates the load: low byte buffer[7:0], then the high byte of the next word.
  - When the low byte is loaded: buffer marked empty, internal address +1, next read issued.
  - If the buffer is empty at a high-byte load: send UNDERRUN_BYTE for both bytes of that word, set underrun, do not advance the address.
- Transmit:
  - SPI_DO = transmit register bit 7, valid immediately after load.
  - On each falling SCK edge within a byte, shift left.
  - Word order is high byte first, matching the download path.
- Read FSM:
  - RD_IDLE → RD_REQ when ioctl_upload=1 and buffer empty.
  - RD_REQ: ioctl_rd=1 for 1 cycle, ioctl_addr=internal address, → RD_WAIT.
  - RD_WAIT: count DATA_LAT cycles, capture ioctl_din into the buffer, buffer valid, → RD_FULL.
  - RD_FULL → RD_REQ once the low byte has been consumed.
  - FILE_RX with zero argument, or reset, → RD_IDLE from any state. A capture in flight is discarded.
- Simultaneous events: a low-byte consume and a capture completing in the same cycle cannot occur, because capture only follows consume. A FILE_RX restart mid-read aborts the read and issues a fresh read at address 0.
- Latency: from low-byte consume to buffer valid is 1 + DATA_LAT + 1 cycles. This must be shorter than 8 SCK periods.
- ioctl_addr is 25 bits and wraps from 0x1FFFFFF to 0.

Optional Feature:
- Macro: DATA_IO_UPLOAD_CLKREF_EN.
- Defined: RD_REQ waits for a rising edge of ioctl_clkref before pulsing ioctl_rd, giving SDRAM-slot alignment.
- Undefined: ioctl_clkref is ignored and ioctl_rd is issued the cycle after entering RD_REQ.

Test Plan:
- Reset mid-upload (reset_n low 3 cycles) → every output 0, spi_do_en=0, SPI_DO=0.
- Send 0x55,0x07 → ioctl_index=0x07. Send 0x56,0x01 → ioctl_upload=1, one ioctl_rd with ioctl_addr=0.
- Memory word0=0xA1B2, word1=0xC3D4. Send 0x57 plus 4 dummy bytes → ARM receives A1,B2,C3,D4. ioctl_rd addresses are 0,1,2. underrun=0.
- DATA_LAT=7 with SCK at clk_sys/4 → no underrun across 64 bytes; bytes match memory.
- Stall memory (hold the capture beyond one word) → high and low bytes both 0xFF, underrun=1, address not advanced. Next word is resent correctly after recovery.
- DATA_IO_UPLOAD_CLKREF_EN with ioctl_clkref toggling every 8 cycles → ioctl_rd only in the cycle after a clkref rise. Send 0x56,0x00 → ioctl_upload=0, no further reads.
